// File: rtl/aibcr3_latch_seq_if.sv
// Request channel into the latch sequencer: valid/ready handshake carrying op, group mask and load data.
interface aibcr3_latch_seq_if #(
  parameter int NGRP = 4,
  parameter int DW   = 8
);
  logic            req_valid;
  logic            req_ready;
  logic            req_op;
  logic [NGRP-1:0] req_mask;
  logic [DW-1:0]   req_data;

  modport master (output req_valid, req_op, req_mask, req_data, input  req_ready);
  modport slave  (input  req_valid, req_op, req_mask, req_data, output req_ready);
endinterface

// File: rtl/aibcr3_latch_seq.sv
// Sequences load/clear requests onto a bank of E/CDN/D configuration latches with fixed setup/pulse/hold windows.
// Latency: done at m*(SETUP+PULSE+HOLD)+1 cycles for a load of m groups, PULSE+1 for a clear, 1 for an empty mask.
// Backpressure: req_ready is high only while idle; requests are never queued.
module aibcr3_latch_seq #(
  parameter int NGRP  = 4,
  parameter int DW    = 8,
  parameter int SETUP = 2,
  parameter int PULSE = 2,
  parameter int HOLD  = 2
) (
  input  logic                clk,
  input  logic                reset,
  aibcr3_latch_seq_if.slave   req_if,
  output logic [DW-1:0]       lat_d,
  output logic [NGRP-1:0]     lat_e,
  output logic [NGRP-1:0]     lat_cdn,
  output logic                busy,
  output logic                done
);

  localparam int MAXW = (SETUP > PULSE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                        : ((PULSE > HOLD) ? PULSE : HOLD);
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic [2:0] {IDLE, LSETUP, LPULSE, LHOLD, CPULSE, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [NGRP-1:0] mask_q, mask_nxt;
  logic [NGRP-1:0] low_bit, first_nxt;
  logic            ready_q;
  logic            accept;

  assign req_if.req_ready = ready_q;
  assign accept           = (state == IDLE) && ready_q && req_if.req_valid;

  // mask_q holds the groups still to visit; the lowest set bit is the current group.
  assign low_bit   = mask_q & (~mask_q + 1'b1);
  assign first_nxt = mask_nxt & (~mask_nxt + 1'b1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mask_nxt  = mask_q;
    case (state)
      IDLE: begin
        if (accept) begin
          mask_nxt = req_if.req_mask;
          if (req_if.req_mask == '0) begin
            state_nxt = DONE;
          end else if (req_if.req_op) begin
            state_nxt = CPULSE;
            cnt_nxt   = CW'(PULSE - 1);
          end else begin
            state_nxt = LSETUP;
            cnt_nxt   = CW'(SETUP - 1);
          end
        end
      end
      LSETUP: begin
        if (cnt == '0) begin
          state_nxt = LPULSE;
          cnt_nxt   = CW'(PULSE - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      LPULSE: begin
        if (cnt == '0) begin
          state_nxt = LHOLD;
          cnt_nxt   = CW'(HOLD - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      LHOLD: begin
        if (cnt == '0) begin
          mask_nxt = mask_q & ~low_bit;
          if (mask_nxt == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = LSETUP;
            cnt_nxt   = CW'(SETUP - 1);
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      CPULSE: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so every pin changes exactly on a window boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      mask_q  <= '0;
      lat_d   <= '0;
      lat_e   <= '0;
      lat_cdn <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mask_q  <= mask_nxt;
      if (accept && !req_if.req_op) begin
        lat_d <= req_if.req_data;
      end
      lat_e   <= (state_nxt == LPULSE) ? first_nxt : '0;
      lat_cdn <= (state_nxt == CPULSE) ? ~mask_nxt : '1;
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
      ready_q <= (state_nxt == IDLE);
    end
  end

endmodule

// File: doc/aibcr3_latch_seq.md
# aibcr3_latch_seq

Sequencer for a bank of resettable configuration latches (E/CDN/D/Q cells) in the AIB PHY configuration path. It accepts load or clear requests over a valid/ready handshake. For each selected latch group it walks through fixed setup, enable-pulse and hold windows, so latch timing never depends on when a request happens to arrive. It sits between the register/config interface and the latch bank, and it is the only driver of the bank's E, CDN and D pins.

## Interface
- NGRP, 4: number of latch groups; one E and one CDN line per group.
- DW, 8: latch data width, shared by all groups.
- SETUP, 2: cycles `lat_d` is stable before `lat_e` rises (≥1).
- PULSE, 2: cycles `lat_e` (load) or `lat_cdn` low (clear) is asserted (≥1).
- HOLD, 2: cycles `lat_d` is held after `lat_e` falls (≥1).
- clk  in  1  Single clock; all state and outputs are registered on its rising edge.
- reset  in  1  Reset is synchronous and active-high.
- req_valid  in  1  Request present.
- req_ready  out  1  High only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both high.
- req_op  in  1  Operation select: 0 = load, 1 = clear.
- req_mask  in  NGRP  Groups to operate on.
- req_data  in  DW  Load data; ignored when req_op=1.
- lat_d  out  DW  Latch D bus, common to all groups.
- lat_e  out  NGRP  Per-group latch enable; at most one bit is high at any time.
- lat_cdn  out  NGRP  Per-group active-low latch clear.
- busy  out  1  High from the cycle after accept through the DONE cycle.
- done  out  1  One-cycle pulse marking completion of a request.

## Operation
- States:
  - IDLE
  - LSETUP, LPULSE, LHOLD (load)
  - CPULSE (clear)
  - DONE
- One down-counter, sized for max(SETUP, PULSE, HOLD), times every window.
- Accept (in IDLE):
  - Register req_mask, req_op and req_data.
  - `lat_d` is updated from req_data on a load accept only. It keeps its value across clears and idle periods.
- Load:
  - Visit set mask bits in ascending index order.
  - Per group: LSETUP (SETUP cycles) → LPULSE (PULSE cycles, `lat_e[k]`=1) → LHOLD (HOLD cycles).
  - After LHOLD, go to the next set bit's LSETUP, or to DONE after the last set bit.
- Clear:
  - CPULSE lasts PULSE cycles, with `lat_cdn[k]`=0 for every masked k simultaneously.
  - Then DONE.
- Mask zero, either op: go straight to DONE. No `lat_e` or `lat_cdn` activity occurs.
- DONE lasts one cycle, asserts `done`, then returns to IDLE.
- Requests are not queued. While not in IDLE, req_ready=0 and req_valid is ignored.
- `lat_e` and `lat_cdn` are never active in the same cycle.
- `lat_cdn` for unmasked groups stays at 1 outside reset.

## Timing
- Reset values, in effect from the edge that samples reset=1:
  - state = IDLE
  - `lat_e` = 0
  - `lat_cdn` = all 0 (latch bank held cleared during reset)
  - `lat_d` = 0
  - busy = 0, done = 0, req_ready = 0
- First cycle after reset deasserts: `lat_cdn` = all 1, req_ready = 1.
- Reset mid-operation aborts immediately at that edge:
  - `lat_e` drops to 0 and all groups are cleared.
  - No `done` pulse is produced.
- Accept at edge T (load, m set mask bits):
  - Group j (0-based visit order) starts at T+1+j·(SETUP+PULSE+HOLD).
  - `lat_e` is high from start+SETUP through start+SETUP+PULSE−1.
  - `done` is at T+1+m·(SETUP+PULSE+HOLD).
  - req_ready returns to 1 the cycle after `done`.
- Accept at T (clear, mask≠0): `lat_cdn` low at T+1..T+PULSE; `done` at T+1+PULSE.
- Mask zero: `done` at T+1, req_ready = 1 at T+2.
- busy = 1 from T+1 through the `done` cycle inclusive.
- No combinational path from any input to any output.

## Test plan
- **Reset:**
  - Stimulus: hold reset 3 cycles, then release.
  - Required: during reset `lat_cdn`=4'b0000, `lat_e`=0, `lat_d`=0, req_ready=0.
  - Required: the next cycle `lat_cdn`=4'b1111 and req_ready=1.
- **Single load (defaults):**
  - Stimulus: accept at T with op=0, mask=4'b0100, data=8'hA5.
  - Required: `lat_d`=8'hA5 from T+1.
  - Required: `lat_e`=4'b0100 at T+3 and T+4 only.
  - Required: `done` at T+7; req_ready=1 at T+8.
- **Multi-group load:**
  - Stimulus: mask=4'b1011.
  - Required: `lat_e` bit 0 at T+3..T+4, bit 1 at T+9..T+10, bit 3 at T+15..T+16.
  - Required: `done` at T+19; `lat_e` is never multi-hot.
- **Clear:**
  - Stimulus: op=1, mask=4'b0110.
  - Required: `lat_cdn`=4'b1001 at T+1..T+2, 4'b1111 otherwise.
  - Required: `lat_e`=0 throughout; `lat_d` unchanged; `done` at T+3.
- **Mask zero and busy-time requests:**
  - Stimulus: mask=0 accepted at T.
  - Required: `done` at T+1 with no E/CDN activity.
  - Stimulus: hold req_valid=1 during a load.
  - Required: no second accept until req_ready=1.
- **Reset mid-pulse:**
  - Stimulus: assert reset at T+4 of a single-group load.
  - Required: from that edge `lat_e`=0 and `lat_cdn`=0.
  - Required: no `done` pulse; the block is in IDLE after release.
